// File: rtl/wb_decompressor_pkg.sv
// Shared CW link definitions: bus widths, A1 header field positions and the
// responder state encodings (also used by the compressor at the near end).
package wb_decompressor_pkg;

    localparam int RW        = 16;
    localparam int WB_ADDR_W = 24;

    localparam int CW_A1_WE      = 15;
    localparam int CW_A1_SEL_HI  = 14;
    localparam int CW_A1_SEL_LO  = 13;
    localparam int CW_A1_B8      = 12;
    localparam int CW_A1_B4      = 11;
    localparam int CW_A1_ADRH_HI = 7;
    localparam int CW_A1_ADRH_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADRH  = 3'd1,
        ST_WDAT  = 3'd2,
        ST_BUS   = 3'd3,
        ST_RESP  = 3'd4,
        ST_ERR   = 3'd5,
        ST_DRAIN = 3'd6
    } cw_state_e;

    // Beat count minus one, so an 8-beat burst fits the 3-bit counter.
    function automatic logic [2:0] cw_beats_m1(input logic b8, input logic b4);
        if (b8) return 3'd7;
        if (b4) return 3'd3;
        return 3'd0;
    endfunction

endpackage

// File: rtl/wb_decompressor_if.sv
// Classic wishbone bundle between the CW decompressor (master) and its slave,
// including the 4/8-beat burst qualifiers.
interface wb_decompressor_if #(
    parameter int RW     = 16,
    parameter int ADDR_W = 24
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [RW-1:0]     dat_w;
    logic [RW-1:0]     dat_r;
    logic [1:0]        sel;
    logic              ack;
    logic              err;
    logic              burst4;
    logic              burst8;

    modport master (
        output cyc, stb, we, adr, dat_w, sel, burst4, burst8,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel, burst4, burst8,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_decompressor_cw_beat_counter.sv
// Remaining-beat counter for one CW frame: loads 1/4/8 beats (stored minus one),
// steps down once per completed beat and flags the final beat.
module wb_decompressor_cw_beat_counter
    import wb_decompressor_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic load,
    input  logic b8,
    input  logic b4,
    input  logic dec,
    output logic last
);

    logic [2:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= cw_beats_m1(b8, b4);
        end else if (dec && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign last = (cnt == 3'd0);

endmodule

// File: rtl/wb_decompressor.sv
// CW link responder: decodes compressor frames into 16-bit wishbone cycles with
// 4/8-beat bursts. Define CW_TIMEOUT_EN to add the ack watchdog (TIMEOUT_CYC).
module wb_decompressor #(
    parameter int RW     = wb_decompressor_pkg::RW,
    parameter int ADDR_W = wb_decompressor_pkg::WB_ADDR_W
`ifdef CW_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [RW-1:0]     cw_io_i,
    output logic [RW-1:0]     cw_io_o,
    input  logic              cw_req,
    input  logic              cw_dir,
    output logic              cw_ack,
    output logic              cw_err,
    wb_decompressor_if.master wb
);
    import wb_decompressor_pkg::*;

    // state    | meaning
    // IDLE     | waiting for cw_req with cw_dir=1; A0 latched on entry to ADRH
    // ADRH     | A1 header word; opens the wishbone cycle
    // WDAT     | capture write data for the next beat
    // BUS      | wb_stb high, one beat outstanding
    // RESP     | cw_ack pulse, step address or close the cycle
    // ERR      | cw_err pulse, cycle dropped, remaining beats discarded
    // DRAIN    | wait for cw_req to fall

    cw_state_e         state;
    cw_state_e         state_nxt;
    logic              cyc;
    logic              stb;
    logic              we;
    logic              b4;
    logic              b8;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] adr;
    logic [RW-1:0]     dat_w;
    logic [RW-1:0]     rd_data;
    logic              last;
    logic              timeout;
    logic              abort;
    logic              bus_err;
    logic              bus_ack;

    assign abort   = (state != ST_IDLE) && !cw_req;
    assign bus_err = wb.err || timeout;
    assign bus_ack = wb.ack && !bus_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (cw_req && cw_dir) state_nxt = ST_ADRH;
                ST_ADRH:  state_nxt = cw_io_i[CW_A1_WE] ? ST_WDAT : ST_BUS;
                ST_WDAT:  state_nxt = ST_BUS;
                ST_BUS: begin
                    if (bus_err) begin
                        state_nxt = ST_ERR;
                    end else if (wb.ack) begin
                        state_nxt = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (last) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt = we ? ST_WDAT : ST_BUS;
                    end
                end
                ST_ERR:   state_nxt = ST_DRAIN;
                ST_DRAIN: state_nxt = ST_DRAIN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pulses are gated by cw_req so an abort never shows a partial response.
    always_comb begin
        stb    = 1'b0;
        cw_ack = 1'b0;
        cw_err = 1'b0;
        case (state)
            ST_BUS:  stb    = 1'b1;
            ST_RESP: cw_ack = cw_req;
            ST_ERR:  cw_err = cw_req;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc     <= 1'b0;
            we      <= 1'b0;
            sel     <= 2'b00;
            b4      <= 1'b0;
            b8      <= 1'b0;
            adr     <= '0;
            dat_w   <= '0;
            rd_data <= '0;
        end else if (abort) begin
            cyc <= 1'b0;
            we  <= 1'b0;
            sel <= 2'b00;
            b4  <= 1'b0;
            b8  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cw_req && cw_dir) adr[15:0] <= cw_io_i;
                end
                ST_ADRH: begin
                    adr <= ADDR_W'({cw_io_i[CW_A1_ADRH_HI:CW_A1_ADRH_LO], adr[15:0]});
                    cyc <= 1'b1;
                    we  <= cw_io_i[CW_A1_WE];
                    sel <= cw_io_i[CW_A1_SEL_HI:CW_A1_SEL_LO];
                    b8  <= cw_io_i[CW_A1_B8];
                    b4  <= cw_io_i[CW_A1_B4];
                end
                ST_WDAT: dat_w <= cw_io_i;
                ST_BUS: begin
                    // Read data stays on cw_io_o until the next read beat lands.
                    if (bus_ack && !we) rd_data <= wb.dat_r;
                end
                ST_RESP: begin
                    if (last) begin
                        cyc <= 1'b0;
                        we  <= 1'b0;
                        sel <= 2'b00;
                        b4  <= 1'b0;
                        b8  <= 1'b0;
                    end else begin
                        adr <= adr + ADDR_W'(1);
                    end
                end
                ST_ERR: begin
                    cyc <= 1'b0;
                    we  <= 1'b0;
                    sel <= 2'b00;
                    b4  <= 1'b0;
                    b8  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    wb_decompressor_cw_beat_counter u_cw_beat_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (state == ST_ADRH),
        .b8      (cw_io_i[CW_A1_B8]),
        .b4      (cw_io_i[CW_A1_B4]),
        .dec     (state == ST_RESP),
        .last    (last)
    );

`ifdef CW_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;

    logic [TMO_W-1:0] tmo_cnt;

    // Down-counter reloads outside BUS so every beat gets a full window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
        end else if (state != ST_BUS) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end

    assign timeout = (state == ST_BUS) && (tmo_cnt == '0);
`else
    assign timeout = 1'b0;
`endif

    assign cw_io_o   = rd_data;
    assign wb.cyc    = cyc;
    assign wb.stb    = stb;
    assign wb.we     = we;
    assign wb.adr    = adr;
    assign wb.dat_w  = dat_w;
    assign wb.sel    = sel;
    assign wb.burst4 = b4;
    assign wb.burst8 = b8;

endmodule

// File: doc/wb_decompressor.md
Name: wb_decompressor

Overview:
- Far (responder) end of the compressed-wishbone (CW) link that the upper core drives out of its compressor.
- Runs in the cw_clk domain: i_clk is cw_clk.
- Decodes CW request frames on cw_io into a classic 16-bit wishbone master cycle, with 4- and 8-beat bursts.
- Returns per-beat cw_ack or cw_err and read data over cw_io_o.

Parameters:
- RW, 16, CW bus / wishbone data width.
- ADDR_W, 24, wishbone address width.
- TIMEOUT_CYC, 255, ack watchdog limit in cycles; used only with CW_TIMEOUT_EN.

Ports:
- i_clk  in  1  CW link clock (cw_clk).
- i_rst_n  in  1  reset, asynchronous, active-low.
- cw_io_i  in  RW  frame words from the compressor.
- cw_io_o  out  RW  read data to the compressor.
- cw_req  in  1  transaction active; held high for the whole frame.
- cw_dir  in  1  1 = compressor drives cw_io, 0 = responder drives.
- cw_ack  out  1  one-cycle beat-complete pulse.
- cw_err  out  1  one-cycle beat-error pulse.
- wb_cyc, wb_stb, wb_we  out  1  wishbone master controls.
- wb_adr  out  ADDR_W  beat address.
- wb_o_dat  out  RW  write data.
- wb_i_dat  in  RW  read data.
- wb_sel  out  2  byte selects.
- wb_ack, wb_err  in  1  slave responses.
- wb_4_burst, wb_8_burst  out  1  burst-length qualifiers, held for the whole cycle.

Behaviour:
- Reset (async, i_rst_n low): state IDLE; all outputs 0, including cw_io_o, cw_ack, cw_err, wb_cyc and wb_stb. Reset mid-cycle drops wb_cyc/wb_stb immediately. No partial ack is ever emitted.
- Frame format:
  - A0 = first word with cw_req high: adr[15:0].
  - A1 = next word: [15] we, [14:13] sel, [12] 8_burst, [11] 4_burst, [10:8] reserved (ignored), [7:0] adr[23:16].
  - Beats: 8_burst → 8, else 4_burst → 4, else 1. If both bits are set, 8 wins.
- State machine:
  - IDLE: cw_req=1 and cw_dir=1 → latch A0, go ADRH.
  - ADRH: latch A1. we=1 → WDAT; we=0 → BUS. On leaving ADRH, assert wb_cyc, burst qualifiers and sel.
  - WDAT: capture cw_io_i into wb_o_dat → BUS.
  - BUS: wb_stb=1. Exactly one beat outstanding; stb drops the cycle after ack/err.
    - wb_ack → RESP.
    - wb_err → ERR.
  - RESP: cw_ack=1 for one cycle. On a read, cw_io_o = captured wb_i_dat (registered at ack, valid from the cw_ack cycle and held until the next capture). Then, with beat counter decremented:
    - remaining>0 → wb_adr += 1 (mod 2^ADDR_W) and go WDAT (write) or BUS (read).
    - remaining=0 → drop wb_cyc, go DRAIN.
  - ERR: cw_err=1 for one cycle; drop wb_cyc; remaining beats discarded → DRAIN.
  - DRAIN: wait for cw_req=0 → IDLE. A new frame requires cw_req low for ≥1 cycle.
- The compressor presents the next write data in the cycle after cw_ack.
- cw_req falling in any non-IDLE state aborts: wb_cyc/wb_stb low next cycle, no cw_ack/cw_err, go IDLE.
- wb_ack and wb_err asserted together: treated as err.
- cw_dir is sampled only in IDLE; cw_io_i is sampled only in IDLE, ADRH and WDAT.
- Single read latency: A0 at cycle 0 → wb_stb from cycle 2; cw_ack the cycle after wb_ack.
- Beat counter is 3 bits; no wrap beyond the programmed length.

Optional Feature:
- CW_TIMEOUT_EN defined: an 8-bit+ counter runs while in BUS and clears on leaving BUS. Reaching TIMEOUT_CYC behaves exactly as wb_err (ERR: cw_err pulse, cycle dropped).
- CW_TIMEOUT_EN undefined: no counter; BUS waits indefinitely.

Decomposition:
- Shared package/config header holds:
  - RW and WB_ADDR_W.
  - A1 field bit positions (CW_A1_WE=15, CW_A1_SEL=14:13, CW_A1_B8=12, CW_A1_B4=11, CW_A1_ADRH=7:0).
  - State encodings, shared with the compressor.
- One natural sub-module, cw_beat_counter: loads 1/4/8, decrements on ack, flags last beat. Everything else stays in the top FSM.

Test Plan:
- Single write: A0=0x1001, A1=0x8000|0x00 (we, sel=00), data 0x0005 → one wb cycle, adr 0x001001, dat 0x0005; one cw_ack.
- Single read: A0=0x2000, A1=0x6012 (sel=11, adr hi 0x12); slave returns 0xBEEF after 3 wait states → wb_adr 0x122000; cw_ack with cw_io_o=0xBEEF.
- 8-beat read burst at 0xFFFFFC: slave data 0x0000..0x0007 → 8 cw_acks; addresses wrap to 0x000000..0x000003; wb_8_burst held; wb_cyc drops after beat 8.
- 4-beat write burst, wb_err on beat 2 → acks on beat 1 only, cw_err once, beats 3-4 never issued; DRAIN until cw_req low.
- cw_req dropped during BUS of a read; also i_rst_n pulsed mid-burst → wb_cyc/wb_stb fall; no cw_ack; next frame decodes correctly.
- CW_TIMEOUT_EN with TIMEOUT_CYC=16 and a slave that never acks → cw_err exactly 16 cycles after wb_stb rose; without the macro, cw_err never asserts.
